// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
// Module   : uart_defs (package)
// Brief    : Shared state encodings, error codes and default sync byte for
//            the UART frame controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_defs;

   // Frame start marker used when the instantiating design does not override it
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Frame parser states
   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_GET_LEN     = 2'd1;
   localparam logic [1:0] ST_GET_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_GET_CHK     = 2'd3;

   // Drop causes reported on error_code
   localparam logic [1:0] ERR_BAD_LEN    = 2'b01;
   localparam logic [1:0] ERR_BAD_CHK    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

endpackage
`default_nettype wire

// File: rtl/frame_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timeout_timer
// Brief    : Inter-byte watchdog. Counts enabled cycles since the last clear
//            and flags expiry when the count sits at TIMEOUT_CLKS-1 without a
//            clear in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timeout_timer #(
   parameter int TIMEOUT_CLKS = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CLKS + 1);

   logic [CW-1:0] count;

   // Clear has priority so a byte arriving on the expiry cycle wins
   assign expire = enable && !clear && (count == CW'(TIMEOUT_CLKS - 1));

   // Cycle counter: reset/clear to zero, otherwise count while enabled
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_controller
// Brief    : Parses SYNC, LEN, payload, CHK frames from a byte strobe stream,
//            publishing good payloads and flagging dropped frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_controller
   import uart_defs::*;
#(
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int         MAX_LEN      = 4,
   parameter int         TIMEOUT_CLKS = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_byte_ready,
   input  logic [7:0]  rx_data,
   output logic [31:0] par_data,
   output logic [2:0]  par_len,
   output logic        par_valid,
   output logic        frame_error,
   output logic [1:0]  error_code,
   output logic        busy
);

   localparam logic [7:0] MAX_LEN_BYTE = 8'(MAX_LEN);

   logic [1:0]  state;
   logic [2:0]  len;
   logic [1:0]  idx;
   logic [7:0]  chk;
   logic [31:0] shadow;
   logic        expire;

   assign busy = (state != ST_IDLE);

   // Counter idles at zero in IDLE, so entering GET_LEN always starts fresh
   frame_timeout_timer #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (rx_byte_ready || !busy),
      .enable (busy),
      .expire (expire)
   );

   // Frame parser: byte strobes advance the state, timeout drops the frame
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         len         <= '0;
         idx         <= '0;
         chk         <= '0;
         shadow      <= '0;
         par_data    <= '0;
         par_len     <= '0;
         par_valid   <= 1'b0;
         frame_error <= 1'b0;
         error_code  <= '0;
      end else begin
         par_valid   <= 1'b0;
         frame_error <= 1'b0;
         if (rx_byte_ready) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state <= ST_GET_LEN;
                  end
               end
               ST_GET_LEN: begin
                  if (rx_data == 8'd0 || rx_data > MAX_LEN_BYTE) begin
                     frame_error <= 1'b1;
                     error_code  <= ERR_BAD_LEN;
                     state       <= ST_IDLE;
                  end else begin
                     // Zeroing the shadow leaves unused upper bytes at zero
                     len    <= rx_data[2:0];
                     idx    <= '0;
                     chk    <= rx_data;
                     shadow <= '0;
                     state  <= ST_GET_PAYLOAD;
                  end
               end
               ST_GET_PAYLOAD: begin
                  shadow[{idx, 3'b000} +: 8] <= rx_data;
                  chk <= chk ^ rx_data;
                  idx <= idx + 2'd1;
                  if ({1'b0, idx} == len - 3'd1) begin
                     state <= ST_GET_CHK;
                  end
               end
               ST_GET_CHK: begin
                  if (rx_data == chk) begin
                     par_data  <= shadow;
                     par_len   <= len;
                     par_valid <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                     error_code  <= ERR_BAD_CHK;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (expire) begin
            frame_error <= 1'b1;
            error_code  <= ERR_TIMEOUT;
            state       <= ST_IDLE;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_frame_controller.md
UART_FRAME_CONTROLLER -- requirements
Module: uart_frame_controller

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 4, the maximum payload length in bytes (range 1..4).
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 1000, the maximum clocks allowed between bytes inside a frame.
REQ-004 SHALL have port clock  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_byte_ready  input  1  one-cycle strobe marking a valid received byte.
REQ-007 SHALL have port rx_data  input  8  received byte, valid only when rx_byte_ready=1.
REQ-008 SHALL have port par_data  output  32  assembled payload; byte 0 in [7:0].
REQ-009 SHALL have port par_len  output  3  payload byte count of the last good frame.
REQ-010 SHALL have port par_valid  output  1  one-cycle strobe marking a new good frame.
REQ-011 SHALL have port frame_error  output  1  one-cycle strobe marking a dropped frame.
REQ-012 SHALL have port error_code  output  2  cause of drop: 01 bad length, 10 bad checksum, 11 timeout.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL accept the frame format SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-015 SHALL implement states IDLE, GET_LEN, GET_PAYLOAD and GET_CHK, all registered.
REQ-016 In IDLE, a strobe with rx_data==SYNC_BYTE SHALL move to GET_LEN; any other byte SHALL be ignored without error.
REQ-017 In GET_LEN, LEN in 1..MAX_LEN SHALL load the length, clear the byte index and running XOR (seeded with LEN), and move to GET_PAYLOAD.
REQ-018 In GET_LEN, LEN==0 or LEN>MAX_LEN SHALL pulse frame_error with code 01 and return to IDLE.
REQ-019 In GET_PAYLOAD, each strobe SHALL store the byte at byte index, XOR it into the checksum and increment the index; the strobe of byte LEN-1 SHALL move to GET_CHK.
REQ-020 In GET_CHK, a matching byte SHALL update par_data and par_len and pulse par_valid; a mismatch SHALL pulse frame_error with code 10; both paths SHALL return to IDLE.
REQ-021 par_valid and frame_error SHALL assert on the clock edge following the deciding strobe cycle (1-cycle latency) and SHALL last exactly one cycle.
REQ-022 Payload SHALL be staged in a shadow register; par_data SHALL change only on a good frame, with bytes at index >= LEN written as zero.
REQ-023 par_data, par_len and error_code SHALL hold their values between strobes.
REQ-024 The inter-byte counter SHALL clear on entering GET_LEN and on every strobe, and increment in every other non-IDLE cycle.
REQ-025 When the counter reaches TIMEOUT_CLKS-1 with no strobe, the block SHALL pulse frame_error with code 11 and return to IDLE.
REQ-026 A strobe in the same cycle as timeout expiry SHALL take priority and be processed normally.
REQ-027 A SYNC_BYTE value inside a frame SHALL be treated as data, not as a restart.
REQ-028 par_valid and frame_error SHALL never assert in the same cycle.

Reset
REQ-029 Reset SHALL force state IDLE, par_data=0, par_len=0, par_valid=0, frame_error=0, error_code=0, busy=0, and clear the counter, index, XOR and shadow register.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame without pulsing frame_error.

Structure
REQ-031 State encodings, error codes and the default SYNC_BYTE SHALL be defined in the shared uart_defs package/include.
REQ-032 The inter-byte timeout SHALL be a sub-module named frame_timeout_timer with clear, enable and expire ports.

Verification
REQ-033 Bench SHALL cover the good frame A5,02,11,22,CHK=31 -> par_valid for 1 cycle, par_data=32'h00002211, par_len=2.
REQ-034 Bench SHALL cover the bad checksum A5,01,55,00 -> frame_error with code 10, par_data unchanged.
REQ-035 Bench SHALL cover bad lengths A5,00 and A5,05 -> frame_error with code 01 each, return to IDLE, busy=0.
REQ-036 Bench SHALL cover a stall of A5,03,AA then TIMEOUT_CLKS idle clocks -> frame_error with code 11 exactly TIMEOUT_CLKS cycles after the AA strobe.
REQ-037 Bench SHALL cover reset asserted after A5,04,01 -> no pulses; a following good frame A5,01,7E,7F -> par_data=32'h0000007E.
REQ-038 Bench SHALL cover noise bytes 00,FF before the sync byte and an A5 inside the payload (A5,01,A5,A4) -> noise ignored, par_data=32'h000000A5.
